// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: self-running exhaustive checker for an N_IN-input,
// 1-output combinational block. It walks stim through every input vector,
// holds each one for SETTLE+1 cycles, samples dut_out in the last cycle of
// that window and compares it with the EXPECTED truth table. It reports the
// mismatch count, the first failing vector and an overall pass flag.
module truth_table_sweeper #(
  parameter int                      N_IN        = 4,
  parameter int                      SETTLE      = 1,
  parameter logic [(1<<N_IN)-1:0]    EXPECTED    = 16'hAEEE,
  parameter bit                      STOP_ON_ERR = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              dut_out,
  output logic [N_IN-1:0]   stim,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [N_IN:0]     err_count,
  output logic [N_IN-1:0]   first_err_idx,
  output logic              first_err_vld
);

  localparam logic [3:0]      SETTLE_C = 4'(SETTLE);
  localparam logic [N_IN-1:0] LAST_IDX = {N_IN{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [N_IN-1:0]   idx;
  logic [3:0]        cnt;

  // Decode signals produced by the next-state logic.
  logic              accept;    // start taken in IDLE
  logic              sample;    // last cycle of the current vector window
  logic              mismatch;  // dut_out disagrees with the table this cycle
  logic [N_IN:0]     err_nxt;   // error count including this cycle's compare

  // Mismatch count after the compare made in this cycle (if any).
  function automatic logic [N_IN:0] count_step(input logic [N_IN:0] cur,
                                               input logic         hit);
    count_step = cur + {{N_IN{1'b0}}, hit};
  endfunction

  // State register; reset returns to IDLE and drops any sweep in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode: accept start, detect sample point, choose exit.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sample    = 1'b0;
    mismatch  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (cnt == SETTLE_C) begin
          sample   = 1'b1;
          mismatch = (dut_out != EXPECTED[idx]);
          if ((idx == LAST_IDX) || (STOP_ON_ERR && mismatch)) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        // start is deliberately ignored here so it is never queued.
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
    err_nxt = count_step(err_count, mismatch);
  end

  // Sweep datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx           <= '0;
      cnt           <= '0;
      stim          <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      pass          <= 1'b0;
      err_count     <= '0;
      first_err_idx <= '0;
      first_err_vld <= 1'b0;
    end else begin
      busy <= (state_nxt == RUN);
      done <= (state_nxt == DONE);

      if (accept) begin
        idx           <= '0;
        stim          <= '0;
        cnt           <= '0;
        err_count     <= '0;
        pass          <= 1'b0;
        first_err_vld <= 1'b0;
      end

      if (state == RUN) begin
        if (!sample) begin
          cnt <= cnt + 4'd1;
        end else begin
          if (mismatch) begin
            err_count <= err_nxt;
            if (!first_err_vld) begin
              first_err_idx <= idx;
              first_err_vld <= 1'b1;
            end
          end
          if (state_nxt == DONE) begin
            // stim is left on the last (or failing) vector.
            pass <= (err_nxt == '0);
          end else begin
            idx  <= idx + 1'b1;
            stim <= idx + 1'b1;
            cnt  <= '0;
          end
        end
      end
    end
  end

endmodule
